per2axi_req_buffer: RTL
=======================

Name: per2axi_req_buffer

Overview:
Parametrised successor of the peripheral-to-AXI request path. Accepts 32-bit peripheral-interconnect requests into a DEPTH-entry request FIFO and issues them on AXI4 AW/W/AR with fully compliant handshakes: valid is held until ready, AW and W complete independently. Supports any AXI data width from 32 bits upward via lane steering. Sits between the peripheral slave port and the AXI master port. The response channel consumes trans_* to tag outstanding reads.

Parameters:
PER_ADDR_WIDTH, 32, peripheral address width
PER_ID_WIDTH, 5, one-hot peripheral ID width
AXI_ADDR_WIDTH, 32, AXI address width (>= PER_ADDR_WIDTH; zero-extended)
AXI_DATA_WIDTH, 64, AXI data width, power of 2, >= 32
AXI_ID_WIDTH, 3, AXI ID width, >= clog2(PER_ID_WIDTH)
DEPTH, 2, request FIFO entries, power of 2, >= 1
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
per_slave_req_i/add_i/we_i/wdata_i/be_i/id_i  in  1/PER_ADDR_WIDTH/1/32/4/PER_ID_WIDTH  request; we_i=0 write, we_i=1 read
per_slave_gnt_o  out  1  request accepted this cycle
axi_master_aw_valid_o/addr_o/size_o/burst_o/len_o/id_o  out  1/AXI_ADDR_WIDTH/3/2/8/AXI_ID_WIDTH  write address
axi_master_aw_ready_i  in  1
axi_master_w_valid_o/data_o/strb_o/last_o  out  1/AXI_DATA_WIDTH/AXI_STRB_WIDTH/1  write data
axi_master_w_ready_i  in  1
axi_master_ar_valid_o/addr_o/size_o/burst_o/len_o/id_o  out  1/AXI_ADDR_WIDTH/3/2/8/AXI_ID_WIDTH  read address
axi_master_ar_ready_i  in  1
trans_req_o/trans_id_o/trans_add_o  out  1/AXI_ID_WIDTH/AXI_ADDR_WIDTH  pulse on AR handshake, with its ID and address
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: FIFO empty, FSM IDLE. All valid outputs, gnt, trans_req and busy are 0. Data/addr outputs are 0.
- Grant: per_slave_gnt_o = req_i && !full. Depends only on registered occupancy; no push-through when full, even if a pop occurs in the same cycle. Granted request is pushed at the clock edge.
- FIFO: stores add, we, wdata, be, id. Occupancy counter 0..DEPTH with wrapping read/write pointers. Simultaneous push and pop leaves the count unchanged. Pop occurs when the FSM completes the head entry.
- Head decode is combinational from the FIFO head:
  - ID: binary index of the highest set bit of id; all-zero gives 0.
  - Lane: add[clog2(AXI_STRB_WIDTH)-1:2], or lane 0 when AXI_DATA_WIDTH=32. wdata and be are placed in that 32-bit lane; all other data and strb bits are 0.
  - size: be one-hot gives 0. be in {0011, 0110, 1100} gives 1. be=1111 or any other pattern gives 2; strb still equals the shifted be.
  - len=0, burst=INCR (01), w_last=1 whenever w_valid=1.
- FSM:
  - IDLE: if FIFO non-empty, go to WR if head.we=0, else RD. Outputs are asserted one cycle after the state change.
  - WR: aw_valid=1 and w_valid=1.
    - AW and W handshake together: pop, go to IDLE.
    - AW only: go to WR_W (aw_valid drops, w_valid held).
    - W only: go to WR_AW (w_valid drops, aw_valid held).
  - WR_W: w_valid=1; on w_ready, pop and go to IDLE.
  - WR_AW: aw_valid=1; on aw_ready, pop and go to IDLE.
  - RD: ar_valid=1; on ar_ready, pop, pulse trans_req_o for that cycle, go to IDLE.
- AXI stability: while any valid is high, its payload is held stable. Payload comes from the FIFO head, which does not move until pop. Valids never depend combinationally on readys.
- Throughput: one AXI transaction per 2 cycles minimum (IDLE bubble). Reads and writes issue strictly in grant order.
- Reset mid-operation: asserting rst_i discards FIFO contents and any in-flight valid asynchronously; the next cycle after deassertion behaves as post-reset.

Test Plan:
- DW=64, write add=0x104, wdata=0xDEADBEEF, be=1111, id=5'b00100, readys high -> gnt same cycle.
  - 2 cycles later: aw_valid=w_valid=1, aw_addr=0x104, aw_id=2, size=2, w_data=0xDEADBEEF_00000000, strb=0xF0, last=1. Pop after one cycle.
- DW=128, read add=0x20C, be=0011, id=5'b10000 -> ar_valid, ar_id=4, size=1, ar_addr=0x20C.
  - On ar_ready, trans_req_o=1 for 1 cycle with trans_id=4, trans_add=0x20C.
- Write with aw_ready=1, w_ready=0 for 3 cycles -> aw_valid drops after 1 cycle. w_valid held with stable data for 3 cycles, pops when w_ready rises.
- Write with w_ready first, aw_ready 2 cycles later -> transitions WR -> WR_AW -> IDLE. Exactly one AW and one W beat.
- DEPTH=2, all readys low, 3 back-to-back requests -> first 2 granted, third gnt=0 until the first pop. Order write, read, write preserved on AXI.
- Assert rst_i while ar_valid=1 -> ar_valid, busy_o and gnt go 0 immediately. No trans_req afterwards. FIFO empty after reset.

Source files
------------

// File: rtl/per2axi_req_buffer.sv
// Peripheral request FIFO feeding AXI4 AW/W/AR; a request reaches AXI valid two cycles after grant.
// Valids are held until ready, and AW and W complete independently. Grant drops while the FIFO is full.
module per2axi_req_buffer #(
   parameter int PER_ADDR_WIDTH = 32,
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int DEPTH          = 2,
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      per_slave_req_i,
   input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
   input  logic                      per_slave_we_i,
   input  logic [31:0]               per_slave_wdata_i,
   input  logic [3:0]                per_slave_be_i,
   input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
   output logic                      per_slave_gnt_o,
   output logic                      axi_master_aw_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
   output logic [2:0]                axi_master_aw_size_o,
   output logic [1:0]                axi_master_aw_burst_o,
   output logic [7:0]                axi_master_aw_len_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
   input  logic                      axi_master_aw_ready_i,
   output logic                      axi_master_w_valid_o,
   output logic [AXI_DATA_WIDTH-1:0] axi_master_w_data_o,
   output logic [AXI_STRB_WIDTH-1:0] axi_master_w_strb_o,
   output logic                      axi_master_w_last_o,
   input  logic                      axi_master_w_ready_i,
   output logic                      axi_master_ar_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
   output logic [2:0]                axi_master_ar_size_o,
   output logic [1:0]                axi_master_ar_burst_o,
   output logic [7:0]                axi_master_ar_len_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
   input  logic                      axi_master_ar_ready_i,
   output logic                      trans_req_o,
   output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
   output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
   output logic                      busy_o
);

   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int NLANES = AXI_DATA_WIDTH / 32;
   localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;

   typedef struct packed {
      logic [PER_ADDR_WIDTH-1:0] add;
      logic                      we;
      logic [31:0]               wdata;
      logic [3:0]                be;
      logic [PER_ID_WIDTH-1:0]   id;
   } entry_t;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_W, S_WR_AW, S_RD} state_e;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic          push, pop, full, empty;
   entry_t        head;

   logic [AXI_ID_WIDTH-1:0]   head_id;
   logic [LW-1:0]             lane;
   logic [AXI_ADDR_WIDTH-1:0] head_addr;
   logic [AXI_DATA_WIDTH-1:0] head_data;
   logic [AXI_STRB_WIDTH-1:0] head_strb;
   logic [2:0]                head_size;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Grant looks only at registered occupancy, so a same-cycle pop never frees a slot early.
   assign full            = (cnt_q == CW'(DEPTH));
   assign empty           = (cnt_q == '0);
   assign per_slave_gnt_o = per_slave_req_i && !full && !rst_i;
   assign push            = per_slave_gnt_o;
   assign head            = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{add: per_slave_add_i, we: per_slave_we_i, wdata: per_slave_wdata_i,
                             be: per_slave_be_i, id: per_slave_id_i};
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Head decode: one-hot id to binary, 32-bit lane steering, transfer size from byte enables.
   always_comb begin
      head_id = '0;
      for (int i = 0; i < PER_ID_WIDTH; i++)
         if (head.id[i]) head_id = AXI_ID_WIDTH'(i);
      lane      = (NLANES > 1) ? head.add[LW+1:2] : '0;
      head_addr = '0;
      head_addr[PER_ADDR_WIDTH-1:0] = head.add;
      head_data = '0;
      head_data[int'(lane)*32 +: 32] = head.wdata;
      head_strb = '0;
      head_strb[int'(lane)*4 +: 4] = head.be;
      case (head.be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: head_size = 3'd0;
         4'b0011, 4'b0110, 4'b1100:          head_size = 3'd1;
         default:                            head_size = 3'd2;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE:  if (!empty) state_d = head.we ? S_RD : S_WR;
         S_WR: begin
            if (axi_master_aw_ready_i && axi_master_w_ready_i) begin
               pop     = 1'b1;
               state_d = S_IDLE;
            end else if (axi_master_aw_ready_i) state_d = S_WR_W;
            else if (axi_master_w_ready_i)      state_d = S_WR_AW;
         end
         S_WR_W:  if (axi_master_w_ready_i)  begin pop = 1'b1; state_d = S_IDLE; end
         S_WR_AW: if (axi_master_aw_ready_i) begin pop = 1'b1; state_d = S_IDLE; end
         S_RD:    if (axi_master_ar_ready_i) begin pop = 1'b1; state_d = S_IDLE; end
         default: state_d = S_IDLE;
      endcase
   end

   // Valids decode from state only; payloads come straight from the unmoving FIFO head.
   always_comb begin
      axi_master_aw_valid_o = (state_q == S_WR) || (state_q == S_WR_AW);
      axi_master_w_valid_o  = (state_q == S_WR) || (state_q == S_WR_W);
      axi_master_ar_valid_o = (state_q == S_RD);
      trans_req_o           = (state_q == S_RD) && axi_master_ar_ready_i;
      busy_o                = !empty || (state_q != S_IDLE);
   end

   assign axi_master_aw_addr_o  = head_addr;
   assign axi_master_aw_size_o  = head_size;
   assign axi_master_aw_burst_o = 2'b01;
   assign axi_master_aw_len_o   = 8'd0;
   assign axi_master_aw_id_o    = head_id;
   assign axi_master_w_data_o   = head_data;
   assign axi_master_w_strb_o   = head_strb;
   assign axi_master_w_last_o   = axi_master_w_valid_o;
   assign axi_master_ar_addr_o  = head_addr;
   assign axi_master_ar_size_o  = head_size;
   assign axi_master_ar_burst_o = 2'b01;
   assign axi_master_ar_len_o   = 8'd0;
   assign axi_master_ar_id_o    = head_id;
   assign trans_id_o            = head_id;
   assign trans_add_o           = head_addr;

endmodule
